adc_spi_responder: RTL and testbench
====================================

Name: adc_spi_responder

Overview:
- Synthesizable responder for the 4-wire ADC serial interface (adc_sclk, adc_cs_n, adc_din, adc_dout) driven by the Computer_System ADC controller.
- Emulates the 8-channel, 12-bit LTC2308-style ADC so the system can run hardware-in-loop and simulation without the physical converter.
- Per-channel sample values come from a parallel input bus (test pattern source or switches).
- Sits on the board side of the adc_* pins, clocked by the 50 MHz system reference.

Parameters:
- CONV_CYCLES, 80, clk_clk cycles of conversion time after adc_cs_n rises (1.6 us at 50 MHz).
- SYNC_STAGES, 2, synchronizer depth on adc_sclk, adc_cs_n and adc_din (minimum 2).
- FRAME_BITS, 12, adc_sclk cycles per frame; data and config are shifted MSB first.

Ports:
- clk_clk  in  1  system clock; adc_sclk must be ≤ clk_clk/8.
- reset_reset  in  1  synchronous, active-high reset.
- adc_sclk  in  1  serial clock from the controller.
- adc_cs_n  in  1  CONVST/chip select; high = convert, low = transfer frame.
- adc_din  in  1  config bits from the controller, sampled on adc_sclk rising edge.
- adc_dout  out  1  result bits, updated after adc_sclk falling edge.
- ch_data  in  96  channel n value = ch_data[12n+11:12n].
- busy  out  1  conversion in progress.
- cfg_word  out  6  last latched config {S/D, O/S, S1, S0, UNI, SLP}.
- frame_count  out  16  number of completed frames; wraps at 0xFFFF → 0.
- err_conv_violation  out  1  1-cycle pulse: adc_cs_n fell while busy.
- err_short_frame  out  1  1-cycle pulse: adc_cs_n rose before 6 config bits were received.

Behaviour:
- Reset values: adc_dout=0, busy=0, cfg_word=6'b100010 (single-ended, CH0, unipolar), frame_count=0, both err pulses=0, result register=0, state=IDLE. Synchronizer flops are reset to sclk=0, cs_n=1.
- All pin inputs pass through SYNC_STAGES flops; edges are detected on the synchronized values, so edge-to-action latency is SYNC_STAGES+1 clk_clk cycles.
- IDLE: on a cs_n rising edge, latch the config shift register into cfg_word if at least 6 bits were received; otherwise keep the old cfg_word and pulse err_short_frame.
  - A conversion starts in the same cycle: result ← f(ch_data, cfg_word in effect), busy=1, counter=CONV_CYCLES-1, go to CONV.
  - The first cs_n rise after reset also starts a conversion, using the reset cfg_word.
- Channel selection: ch = {O/S, S1, S0}. ch_data is sampled once, at conversion start.
  - S/D=0 (differential) is unsupported: result = 0.
  - UNI=1: result = channel value. UNI=0: result = value ^ 12'h800 (two's complement).
- CONV: the counter decrements each cycle; busy drops to 0 when it reaches 0, then go to IDLE. SLP is stored but has no effect.
- Frame start: on a cs_n falling edge while not busy, adc_dout = result[11] in the next cycle. The data and config shift registers and the bit counter clear; go to SHIFT.
- Frame start during busy: pulse err_conv_violation, enter SHIFT with adc_dout forced to 0 for the whole frame; the conversion continues.
- SHIFT, sclk rise: if bit counter < 6, shift adc_din into config; bit counter +1.
- SHIFT, sclk fall: present the next result bit on adc_dout. Once FRAME_BITS bits have been presented, hold adc_dout=0.
- SHIFT, cs_n rise: frame_count+1 (frame_count increments only from SHIFT), then apply the IDLE rise rules. A frame aborted early (fewer than 12 sclk) still counts.
- Simultaneous sclk and cs_n edges in one cycle: the cs_n edge wins and the sclk edge is ignored.
- reset_reset mid-frame or mid-conversion: immediate return to reset values; the next cs_n rise is treated as the first.

Optional Feature:
- Macro: ADC_SPI_RESPONDER_DITHER_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1, reseeded on reset) advances once per conversion start. LFSR[1:0] is added to the selected channel value before the UNI transform, saturating at 12'hFFF.
- Not defined: no LFSR logic; the result is exact.

Test Plan:
- Reset, then cs_n low/high with no sclk → err_short_frame pulse, cfg_word=6'b100010, busy high for 80 cycles, result = ch_data[11:0].
- ch_data CH5=12'hA5C; frame with din=6'b110110 (S/D=1, ch5, UNI=1), then a second frame → second frame's dout bits = 1010_0101_1100, frame_count=2.
- Config 6'b101000 (ch2, UNI=0), CH2=12'h123 → next frame reads 12'h923.
- cs_n falls 20 cycles after a conversion starts → err_conv_violation pulse, dout=0 for all 12 bits, busy still ends at cycle 80.
- Assert reset_reset at sclk edge 7 of a frame → all outputs return to reset values and frame_count=0; the next full frame behaves as the first.
- With ADC_SPI_RESPONDER_DITHER_EN, CH0=12'hFFF → result stays 12'hFFF (saturates); CH0=12'h100 → result in 12'h100..12'h103.

Source files
------------

// File: rtl/adc_spi_responder.sv
// rtl/adc_spi_responder.sv - LTC2308-style 8-channel 12-bit ADC emulator on the adc_* serial pins
//
// Purpose:
//   Board-side responder for the 4-wire ADC interface. It answers the
//   controller as an 8-channel 12-bit converter would. Channel values come
//   from the parallel ch_data bus and are sampled once, when a conversion starts.
//
// Ports:
//   clk_clk            system clock (adc_sclk must be <= clk_clk/8)
//   reset_reset        synchronous active-high reset
//   adc_sclk           serial clock from the controller
//   adc_cs_n           CONVST / chip select (high = convert, low = frame)
//   adc_din            config bits, sampled on adc_sclk rise, MSB first
//   adc_dout           result bits, updated after adc_sclk fall, MSB first
//   ch_data            channel n value = ch_data[12n+11:12n]
//   busy               conversion in progress
//   cfg_word           last latched config {S/D, O/S, S1, S0, UNI, SLP}
//   frame_count        completed frames, wraps at 16 bits
//   err_conv_violation 1-cycle pulse: adc_cs_n fell while busy
//   err_short_frame    1-cycle pulse: adc_cs_n rose before 6 config bits
//
// Optional feature macro: ADC_SPI_RESPONDER_DITHER_EN
//   When defined, a 16-bit LFSR adds 0..3 to the selected channel value
//   (saturating) at every conversion start.

module adc_spi_responder #(
  parameter int CONV_CYCLES = 80,
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BITS  = 12
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        adc_sclk,
  input  logic        adc_cs_n,
  input  logic        adc_din,
  output logic        adc_dout,
  input  logic [95:0] ch_data,
  output logic        busy,
  output logic [5:0]  cfg_word,
  output logic [15:0] frame_count,
  output logic        err_conv_violation,
  output logic        err_short_frame
);

  localparam int CNT_W = $clog2(CONV_CYCLES + 1);
  localparam int TX_W  = $clog2(FRAME_BITS + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CONV  = 2'd1;
  localparam logic [1:0] ST_SHIFT = 2'd2;

  localparam logic [5:0] CFG_RESET = 6'b100010;

  // Pin synchronizers
  logic [SYNC_STAGES-1:0] sclk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] din_sync_q;
  logic                   sclk_prev_q;
  logic                   cs_prev_q;

  logic sclk_s, cs_s, din_s;
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign din_s     = din_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      din_sync_q  <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], adc_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], adc_cs_n};
      din_sync_q  <= {din_sync_q[SYNC_STAGES-2:0], adc_din};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  // Core state
  logic [1:0]       state_q;
  logic             busy_q;
  logic [CNT_W-1:0] conv_cnt_q;
  logic [11:0]      result_q;
  logic [11:0]      data_sr_q;
  logic [TX_W-1:0]  tx_cnt_q;
  logic [5:0]       cfg_sr_q;
  logic [2:0]       rx_cnt_q;
  logic [5:0]       cfg_word_q;
  logic [15:0]      frame_cnt_q;
  logic             dout_q;
  logic             kill_q;
  logic             err_viol_q;
  logic             err_short_q;
`ifdef ADC_SPI_RESPONDER_DITHER_EN
  logic [15:0]      lfsr_q;
  logic             lfsr_fb;
  logic [12:0]      dith_sum;
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
`endif

  // Conversion result from the config that will be in effect after this cs_n rise
  logic [5:0]  cfg_eff;
  logic [2:0]  ch_sel;
  logic [11:0] ch_val;
  logic [11:0] conv_val;
  logic [11:0] result_d;

  always_comb begin
    cfg_eff = (rx_cnt_q >= 3'd6) ? cfg_sr_q : cfg_word_q;
    ch_sel  = cfg_eff[4:2];
    ch_val  = '0;
    for (int i = 0; i < 8; i++) begin
      if (ch_sel == 3'(i)) ch_val = ch_data[12*i +: 12];
    end
`ifdef ADC_SPI_RESPONDER_DITHER_EN
    dith_sum = {1'b0, ch_val} + {11'b0, lfsr_q[1:0]};
    conv_val = dith_sum[12] ? 12'hFFF : dith_sum[11:0];
`else
    conv_val = ch_val;
`endif
    if (!cfg_eff[5])     result_d = '0;  // differential mode not emulated
    else if (cfg_eff[1]) result_d = conv_val;
    else                 result_d = conv_val ^ 12'h800;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      conv_cnt_q  <= '0;
      result_q    <= '0;
      data_sr_q   <= '0;
      tx_cnt_q    <= '0;
      cfg_sr_q    <= '0;
      rx_cnt_q    <= '0;
      cfg_word_q  <= CFG_RESET;
      frame_cnt_q <= '0;
      dout_q      <= 1'b0;
      kill_q      <= 1'b0;
      err_viol_q  <= 1'b0;
      err_short_q <= 1'b0;
`ifdef ADC_SPI_RESPONDER_DITHER_EN
      lfsr_q      <= 16'hACE1;
`endif
    end else begin
      err_viol_q  <= 1'b0;
      err_short_q <= 1'b0;

      // Conversion timer runs independently of the frame state, so a frame
      // opened during a conversion does not stretch or cut it.
      if (busy_q) begin
        if (conv_cnt_q == '0) begin
          busy_q <= 1'b0;
          if (state_q == ST_CONV) state_q <= ST_IDLE;
        end else begin
          conv_cnt_q <= conv_cnt_q - 1'b1;
        end
      end

      // cs_n edges take priority over any sclk edge in the same cycle
      if (cs_rise) begin
        if (state_q == ST_SHIFT) frame_cnt_q <= frame_cnt_q + 16'd1;
        if (rx_cnt_q >= 3'd6) cfg_word_q <= cfg_sr_q;
        else                  err_short_q <= 1'b1;
        result_q   <= result_d;
        busy_q     <= 1'b1;
        conv_cnt_q <= CNT_W'(CONV_CYCLES - 1);
        state_q    <= ST_CONV;
        rx_cnt_q   <= '0;
        dout_q     <= 1'b0;
`ifdef ADC_SPI_RESPONDER_DITHER_EN
        lfsr_q     <= {lfsr_q[14:0], lfsr_fb};
`endif
      end else if (cs_fall) begin
        if (busy_q) begin
          err_viol_q <= 1'b1;
          kill_q     <= 1'b1;
          dout_q     <= 1'b0;
        end else begin
          kill_q     <= 1'b0;
          dout_q     <= result_q[11];
        end
        data_sr_q <= result_q;
        tx_cnt_q  <= TX_W'(1);
        cfg_sr_q  <= '0;
        rx_cnt_q  <= '0;
        state_q   <= ST_SHIFT;
      end else if (state_q == ST_SHIFT) begin
        if (sclk_rise) begin
          if (rx_cnt_q < 3'd6) begin
            cfg_sr_q <= {cfg_sr_q[4:0], din_s};
            rx_cnt_q <= rx_cnt_q + 3'd1;
          end
        end else if (sclk_fall) begin
          // data_sr_q[11] is already on the pin; bit 10 is the next one out
          if (tx_cnt_q < TX_W'(FRAME_BITS)) begin
            dout_q    <= kill_q ? 1'b0 : data_sr_q[10];
            data_sr_q <= data_sr_q << 1;
            tx_cnt_q  <= tx_cnt_q + 1'b1;
          end else begin
            dout_q <= 1'b0;
          end
        end
      end
    end
  end

  assign adc_dout           = dout_q;
  assign busy               = busy_q;
  assign cfg_word           = cfg_word_q;
  assign frame_count        = frame_cnt_q;
  assign err_conv_violation = err_viol_q;
  assign err_short_frame    = err_short_q;

endmodule

// File: tb/tb_adc_spi_responder.sv
// tb/tb_adc_spi_responder.sv - directed self-checking bench for adc_spi_responder

module tb_adc_spi_responder;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        adc_sclk;
  logic        adc_cs_n;
  logic        adc_din;
  logic        adc_dout;
  logic [95:0] ch_data;
  logic        busy;
  logic [5:0]  cfg_word;
  logic [15:0] frame_count;
  logic        err_conv_violation;
  logic        err_short_frame;

  int tests_run    = 0;
  int tests_failed = 0;
  int busy_cnt     = 0;
  int short_cnt    = 0;
  int viol_cnt     = 0;

  always #10 clk_clk = ~clk_clk;

  adc_spi_responder dut (
    .clk_clk            (clk_clk),
    .reset_reset        (reset_reset),
    .adc_sclk           (adc_sclk),
    .adc_cs_n           (adc_cs_n),
    .adc_din            (adc_din),
    .adc_dout           (adc_dout),
    .ch_data            (ch_data),
    .busy               (busy),
    .cfg_word           (cfg_word),
    .frame_count        (frame_count),
    .err_conv_violation (err_conv_violation),
    .err_short_frame    (err_short_frame)
  );

  always @(negedge clk_clk) begin
    if (busy)               busy_cnt  = busy_cnt + 1;
    if (err_short_frame)    short_cnt = short_cnt + 1;
    if (err_conv_violation) viol_cnt  = viol_cnt + 1;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic set_ch(input int ch, input logic [11:0] v);
    ch_data[12*ch +: 12] = v;
  endtask

  // Opens a frame and runs nsclk serial clocks; cs_n is left low
  task automatic run_frame(input logic [5:0] cfg, input int nsclk,
                           output logic [11:0] rd, output logic tail);
    logic [5:0] c;
    c    = cfg;
    rd   = '0;
    tail = 1'b0;
    adc_cs_n = 1'b0;
    adc_din  = c[5];
    wait_clk(8);
    rd[11] = adc_dout;
    for (int i = 0; i < nsclk; i++) begin
      adc_sclk = 1'b1;
      wait_clk(8);
      adc_sclk = 1'b0;
      if (i < 5) adc_din = c[4-i];
      wait_clk(8);
      if (i < 11) rd[10-i] = adc_dout;
      else        tail     = adc_dout;
    end
  endtask

  task automatic end_frame();
    adc_cs_n = 1'b1;
    adc_din  = 1'b0;
    wait_clk(1);
  endtask

  task automatic frame_and_convert(input logic [5:0] cfg,
                                   output logic [11:0] rd, output logic tail);
    run_frame(cfg, 12, rd, tail);
    end_frame();
    wait_clk(100);
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    adc_cs_n = 1'b1;
    adc_sclk = 1'b0;
    adc_din  = 1'b0;
    wait_clk(4);
    reset_reset = 1'b0;
    wait_clk(1);
    tests_run++;
    if (adc_dout !== 1'b0) begin tests_failed++; $display("FAIL reset_dout: got %b expected 0", adc_dout); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests_run++;
    if (cfg_word !== 6'b100010) begin tests_failed++; $display("FAIL reset_cfg: got %b expected 100010", cfg_word); end
    tests_run++;
    if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL reset_fc: got %0d expected 0", frame_count); end
    tests_run++;
    if ({err_short_frame, err_conv_violation} !== 2'b00) begin
      tests_failed++; $display("FAIL reset_err: got %b expected 00", {err_short_frame, err_conv_violation});
    end
  endtask

  task automatic test_short_frame();
    int b0, s0;
    logic [11:0] rd;
    logic tail;
    b0 = busy_cnt;
    s0 = short_cnt;
    adc_cs_n = 1'b0;
    wait_clk(8);
    adc_cs_n = 1'b1;
    wait_clk(100);
    tests_run++;
    if (busy_cnt - b0 != 80) begin tests_failed++; $display("FAIL short_busy_len: got %0d expected 80", busy_cnt - b0); end
    tests_run++;
    if (short_cnt - s0 != 1) begin tests_failed++; $display("FAIL short_pulse: got %0d expected 1", short_cnt - s0); end
    tests_run++;
    if (cfg_word !== 6'b100010) begin tests_failed++; $display("FAIL short_cfg: got %b expected 100010", cfg_word); end
    tests_run++;
    if (frame_count !== 16'd1) begin tests_failed++; $display("FAIL short_fc: got %0d expected 1", frame_count); end
    frame_and_convert(6'b110110, rd, tail);
    tests_run++;
    if (rd !== 12'h3C5) begin tests_failed++; $display("FAIL short_result_ch0: got %h expected 3c5", rd); end
  endtask

  task automatic test_channel_select();
    logic [11:0] rd;
    logic tail;
    frame_and_convert(6'b110110, rd, tail);
    tests_run++;
    if (rd !== 12'hA5C) begin tests_failed++; $display("FAIL ch5_data: got %h expected a5c", rd); end
    tests_run++;
    if (tail !== 1'b0) begin tests_failed++; $display("FAIL ch5_tail: got %b expected 0", tail); end
    tests_run++;
    if (frame_count !== 16'd3) begin tests_failed++; $display("FAIL ch5_fc: got %0d expected 3", frame_count); end
    tests_run++;
    if (cfg_word !== 6'b110110) begin tests_failed++; $display("FAIL ch5_cfg: got %b expected 110110", cfg_word); end
  endtask

  task automatic test_twos_complement();
    logic [11:0] rd;
    logic tail;
    frame_and_convert(6'b101000, rd, tail);
    tests_run++;
    if (rd !== 12'hA5C) begin tests_failed++; $display("FAIL tc_prev: got %h expected a5c", rd); end
    frame_and_convert(6'b101000, rd, tail);
    tests_run++;
    if (rd !== 12'h923) begin tests_failed++; $display("FAIL tc_ch2: got %h expected 923", rd); end
    tests_run++;
    if (frame_count !== 16'd5) begin tests_failed++; $display("FAIL tc_fc: got %0d expected 5", frame_count); end
  endtask

  task automatic test_conv_violation();
    int b0, v0, k;
    logic [11:0] rd;
    logic tail;
    run_frame(6'b101000, 12, rd, tail);
    b0 = busy_cnt;
    end_frame();
    k = 0;
    while (!busy && k < 10) begin
      wait_clk(1);
      k++;
    end
    tests_run++;
    if (busy !== 1'b1) begin tests_failed++; $display("FAIL viol_busy_start: got %b expected 1", busy); end
    wait_clk(19);
    v0 = viol_cnt;
    run_frame(6'b101000, 12, rd, tail);
    tests_run++;
    if (busy_cnt - b0 != 80) begin tests_failed++; $display("FAIL viol_busy_len: got %0d expected 80", busy_cnt - b0); end
    tests_run++;
    if (viol_cnt - v0 != 1) begin tests_failed++; $display("FAIL viol_pulse: got %0d expected 1", viol_cnt - v0); end
    tests_run++;
    if (rd !== 12'h000) begin tests_failed++; $display("FAIL viol_dout: got %h expected 000", rd); end
    tests_run++;
    if (tail !== 1'b0) begin tests_failed++; $display("FAIL viol_tail: got %b expected 0", tail); end
    end_frame();
    wait_clk(100);
    frame_and_convert(6'b101000, rd, tail);
    tests_run++;
    if (rd !== 12'h923) begin tests_failed++; $display("FAIL viol_after: got %h expected 923", rd); end
    tests_run++;
    if (frame_count !== 16'd8) begin tests_failed++; $display("FAIL viol_fc: got %0d expected 8", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    int s0;
    logic [11:0] rd;
    logic tail;
    run_frame(6'b110110, 3, rd, tail);
    tests_run++;
    if (rd[11:8] !== 4'b1001) begin tests_failed++; $display("FAIL mid_partial: got %b expected 1001", rd[11:8]); end
    tests_run++;
    if (adc_dout !== 1'b1) begin tests_failed++; $display("FAIL mid_dout_pre: got %b expected 1", adc_dout); end
    reset_reset = 1'b1;
    adc_cs_n = 1'b1;
    adc_sclk = 1'b0;
    adc_din  = 1'b0;
    wait_clk(3);
    tests_run++;
    if (adc_dout !== 1'b0) begin tests_failed++; $display("FAIL mid_dout: got %b expected 0", adc_dout); end
    tests_run++;
    if (cfg_word !== 6'b100010) begin tests_failed++; $display("FAIL mid_cfg: got %b expected 100010", cfg_word); end
    tests_run++;
    if (frame_count !== 16'd0) begin tests_failed++; $display("FAIL mid_fc: got %0d expected 0", frame_count); end
    tests_run++;
    if (busy !== 1'b0) begin tests_failed++; $display("FAIL mid_busy: got %b expected 0", busy); end
    reset_reset = 1'b0;
    wait_clk(2);
    s0 = short_cnt;
    frame_and_convert(6'b110110, rd, tail);
    tests_run++;
    if (rd !== 12'h000) begin tests_failed++; $display("FAIL first_rd: got %h expected 000", rd); end
    tests_run++;
    if (frame_count !== 16'd1) begin tests_failed++; $display("FAIL first_fc: got %0d expected 1", frame_count); end
    tests_run++;
    if (cfg_word !== 6'b110110) begin tests_failed++; $display("FAIL first_cfg: got %b expected 110110", cfg_word); end
    tests_run++;
    if (short_cnt != s0) begin tests_failed++; $display("FAIL first_short: got %0d expected %0d", short_cnt, s0); end
    frame_and_convert(6'b110110, rd, tail);
    tests_run++;
    if (rd !== 12'hA5C) begin tests_failed++; $display("FAIL first_next: got %h expected a5c", rd); end
  endtask

`ifdef ADC_SPI_RESPONDER_DITHER_EN
  task automatic test_dither();
    logic [11:0] rd;
    logic tail;
    set_ch(0, 12'hFFF);
    frame_and_convert(6'b100010, rd, tail);
    set_ch(0, 12'h100);
    frame_and_convert(6'b100010, rd, tail);
    tests_run++;
    if (rd !== 12'hFFF) begin tests_failed++; $display("FAIL dither_sat: got %h expected fff", rd); end
    frame_and_convert(6'b100010, rd, tail);
    tests_run++;
    if (rd < 12'h100 || rd > 12'h103) begin
      tests_failed++; $display("FAIL dither_range: got %h expected 100..103", rd);
    end
  endtask
`endif

  initial begin
    reset_reset = 1'b1;
    adc_sclk = 1'b0;
    adc_cs_n = 1'b1;
    adc_din  = 1'b0;
    ch_data  = '0;
    set_ch(0, 12'h3C5);
    set_ch(1, 12'h111);
    set_ch(2, 12'h123);
    set_ch(3, 12'h333);
    set_ch(4, 12'h444);
    set_ch(5, 12'hA5C);
    set_ch(6, 12'h666);
    set_ch(7, 12'h777);
    test_reset();
    test_short_frame();
    test_channel_select();
    test_twos_complement();
    test_conv_violation();
    test_reset_mid_frame();
`ifdef ADC_SPI_RESPONDER_DITHER_EN
    test_dither();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
